// File: rtl/fifo_rd_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_stream_pkg
//  Brief    : Shared width helper for the FIFO read-stream adapter.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_rd_stream_pkg;

  // Bits needed to index n distinct values (minimum 1).
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage : fifo_rd_stream_pkg
`default_nettype wire

// File: rtl/fifo_rd_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_stream_if
//  Brief    : FIFO read port plus valid/ready stream bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface fifo_rd_stream_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );
endinterface : fifo_rd_stream_if
`default_nettype wire

// File: rtl/fifo_rd_stream_prefetch_buf.sv
`default_nettype none
// ============================================================================
//  Module   : stream_prefetch_buf
//  Brief    : Circular prefetch buffer with occupancy and head-of-queue data.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_prefetch_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned OCC_WIDTH  = idx_width(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [OCC_WIDTH-1:0]  occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  localparam int unsigned c_ptr_width = idx_width(DEPTH);
  localparam logic [c_ptr_width-1:0] c_last_ptr = c_ptr_width'(DEPTH - 1);
  localparam logic [OCC_WIDTH-1:0]   c_full_occ = OCC_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
  logic [c_ptr_width-1:0] r_head;
  logic [c_ptr_width-1:0] r_tail;
  logic [OCC_WIDTH-1:0]   r_occ;
  logic                   w_wr;

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [c_ptr_width-1:0] next_ptr(input logic [c_ptr_width-1:0] p);
    return (p == c_last_ptr) ? '0 : p + c_ptr_width'(1);
  endfunction

  assign w_wr = wr_en && !clr;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (clr) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (wr_en) begin
        r_tail <= next_ptr(r_tail);
      end
      if (pop) begin
        r_head <= next_ptr(r_head);
      end
      case ({wr_en, pop})
        2'b10:   r_occ <= r_occ + OCC_WIDTH'(1);
        2'b01:   r_occ <= r_occ - OCC_WIDTH'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_mem
    always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
        r_mem[i] <= '0;
      end else if (w_wr && (r_tail == c_ptr_width'(i))) begin
        r_mem[i] <= wr_data;
      end
    end
  end

  assign occ       = r_occ;
  assign head_data = r_mem[r_head];

  a_no_write_when_full : assert property (
    @(posedge clk) disable iff (!aclr_n)
    !(w_wr && (r_occ == c_full_occ))
  );

  a_no_pop_when_empty : assert property (
    @(posedge clk) disable iff (!aclr_n)
    !(pop && !clr && (r_occ == '0))
  );

endmodule : stream_prefetch_buf
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_stream
//  Brief    : Turns a registered-output sync FIFO read port into a
//             valid/ready stream master with a small prefetch buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BUF_DEPTH  = 3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 aclr_n,
  input  logic                 sclr_n,
  fifo_rd_stream_if.master     bus,
  output logic [CNT_WIDTH-1:0] beat_cnt
);

  localparam int unsigned c_occ_width = idx_width(BUF_DEPTH + 1);

  logic                   r_pend;
  logic [CNT_WIDTH-1:0]   r_beat_cnt;
  logic [c_occ_width-1:0] w_occ;
  logic [DATA_WIDTH-1:0]  w_head_data;
  logic                   w_rd_en;
  logic                   w_valid;
  logic                   w_pop;
  logic                   w_clr;

  assign w_clr = !sclr_n;

  // Reserve a slot for the read already in flight; m_ready is never consulted.
  assign w_rd_en = sclr_n && !bus.fifo_empty
                   && ((32'(w_occ) + 32'(r_pend)) < BUF_DEPTH);

  assign w_valid = (w_occ != '0);
  assign w_pop   = w_valid && bus.m_ready;

  stream_prefetch_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH),
    .OCC_WIDTH  (c_occ_width)
  ) u_buf (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .clr       (w_clr),
    .wr_en     (r_pend),
    .wr_data   (bus.fifo_dout),
    .pop       (w_pop),
    .occ       (w_occ),
    .head_data (w_head_data)
  );

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_pend     <= 1'b0;
      r_beat_cnt <= '0;
    end else if (w_clr) begin
      r_pend     <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_pend <= w_rd_en;
      if (w_pop) begin
        r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = w_valid;
  assign bus.m_data     = w_head_data;
  assign beat_cnt       = r_beat_cnt;

  a_rd_only_when_not_empty : assert property (
    @(posedge clk) disable iff (!aclr_n)
    bus.fifo_rd_en |-> !bus.fifo_empty
  );

  a_stream_stable : assert property (
    @(posedge clk) disable iff (!aclr_n)
    (bus.m_valid && !bus.m_ready && sclr_n) |=> (bus.m_valid && $stable(bus.m_data))
  );

endmodule : fifo_rd_stream
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_stream
//  Brief    : Self-checking bench: behavioural sync FIFO upstream, ordered
//             scoreboard downstream, directed and random steps.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

  localparam int FD = 16;

  logic clk;
  logic aclr_n;
  logic sclr_n;
  logic [15:0] beat_cnt;
  logic [3:0]  beat_cnt4;

  fifo_rd_stream_if #(.DATA_WIDTH(8)) bus  ();
  fifo_rd_stream_if #(.DATA_WIDTH(8)) bus2 ();

  fifo_rd_stream #(.DATA_WIDTH(8), .BUF_DEPTH(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .aclr_n(aclr_n), .sclr_n(sclr_n), .bus(bus), .beat_cnt(beat_cnt)
  );

  // Narrow-counter twin fed the same inputs, used for the wrap check.
  fifo_rd_stream #(.DATA_WIDTH(8), .BUF_DEPTH(3), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .aclr_n(aclr_n), .sclr_n(sclr_n), .bus(bus2), .beat_cnt(beat_cnt4)
  );

  assign bus2.fifo_empty = bus.fifo_empty;
  assign bus2.fifo_dout  = bus.fifo_dout;
  assign bus2.m_ready    = bus.m_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int model_cnt = 0;
  int n_reads = 0;
  logic [7:0] wr_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] fmem [0:FD-1];
  int frd, fwr, fcnt;
  bit hold_prev = 0;
  logic [7:0] prev_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit can_wr();
    return (wr_q.size() != 0) && (fcnt < FD);
  endfunction

  // Upstream sync FIFO: registered empty flag, dout valid the cycle after rd_en.
  always @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      frd <= 0; fwr <= 0; fcnt <= 0;
      bus.fifo_empty <= 1'b1;
      bus.fifo_dout  <= '0;
    end else if (!sclr_n) begin
      frd <= 0; fwr <= 0; fcnt <= 0;
      bus.fifo_empty <= 1'b1;
    end else begin
      fcnt <= fcnt + int'(can_wr()) - int'(bus.fifo_rd_en);
      bus.fifo_empty <= ((fcnt + int'(can_wr()) - int'(bus.fifo_rd_en)) == 0);
      if (bus.fifo_rd_en) begin
        bus.fifo_dout <= fmem[frd];
        frd <= (frd + 1) % FD;
      end
      if (can_wr()) begin
        fmem[fwr] <= wr_q[0];
        fwr <= (fwr + 1) % FD;
        void'(wr_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (aclr_n && sclr_n && bus.fifo_rd_en) n_reads <= n_reads + 1;
  end

  // Scoreboard: accepted beats must follow write order; held beats stay put.
  always @(negedge clk) begin
    if (!aclr_n || !sclr_n) begin
      exp_q.delete();
      model_cnt = 0;
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 32'(bus.m_valid), 1);
        check("hold_data", 32'(bus.m_data), 32'(prev_data));
      end
      if (bus.m_valid && bus.m_ready) begin
        check("beat_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("beat_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
        model_cnt++;
      end
      hold_prev = bus.m_valid && !bus.m_ready;
      prev_data = bus.m_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] w);
    wr_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic do_sclr();
    wr_q.delete();
    sclr_n = 1'b0;
    cyc();
    sclr_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!bus.m_valid && k < 50) begin cyc(); k++; end
    check(tag, 32'(bus.m_valid), 1);
  endtask

  task automatic wait_drain(input string tag, input int limit, input bit rnd);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.m_valid) && k < limit) begin
      if (rnd) bus.m_ready = 1'($urandom_range(0, 1));
      cyc();
      k++;
    end
    bus.m_ready = 1'b1;
    check(tag, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int base, k;
    aclr_n = 1'b0;
    sclr_n = 1'b1;
    bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_rd_en", 32'(bus.fifo_rd_en), 0);
    check("rst_valid", 32'(bus.m_valid), 0);
    check("rst_data", 32'(bus.m_data), 0);
    check("rst_cnt", 32'(beat_cnt), 0);
    aclr_n = 1'b1;
    cyc();

    // Single word: read issued the cycle empty falls, valid two cycles later.
    bus.m_ready = 1'b1;
    base = n_reads;
    send(8'hA5);
    cyc();
    check("single_rd_en", 32'(bus.fifo_rd_en), 1);
    check("single_valid_n", 32'(bus.m_valid), 0);
    cyc();
    check("single_rd_en_off", 32'(bus.fifo_rd_en), 0);
    check("single_valid_n1", 32'(bus.m_valid), 0);
    cyc();
    check("single_valid", 32'(bus.m_valid), 1);
    check("single_data", 32'(bus.m_data), 32'hA5);
    cyc();
    check("single_drained", 32'(bus.m_valid), 0);
    check("single_cnt", 32'(beat_cnt), 1);
    check("single_reads", 32'(n_reads - base), 1);

    // Burst: no bubbles once the first beat appears.
    do_sclr();
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(8'(i));
    wait_valid("burst_first");
    for (int i = 1; i <= 8; i++) begin
      check("burst_valid", 32'(bus.m_valid), 1);
      check("burst_data", 32'(bus.m_data), 32'(i));
      cyc();
    end
    check("burst_cnt", 32'(beat_cnt), 8);

    // Backpressure: only BUF_DEPTH words leave the FIFO.
    do_sclr();
    bus.m_ready = 1'b0;
    base = n_reads;
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
    repeat (20) cyc();
    check("bp_reads", 32'(n_reads - base), 3);
    check("bp_valid", 32'(bus.m_valid), 1);
    check("bp_data", 32'(bus.m_data), 32'h10);
    check("bp_usedw", 32'(fcnt), 5);
    check("bp_rd_idle", 32'(bus.fifo_rd_en), 0);
    bus.m_ready = 1'b1;
    wait_drain("bp_drain", 60, 1'b0);
    check("bp_cnt", 32'(beat_cnt), 8);

    // Synchronous clear while a read is in flight and two words are buffered.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(8'h50 + i));
    k = 0;
    while (!bus.fifo_rd_en && k < 20) begin cyc(); k++; end
    check("sclr_rd_seen", 32'(bus.fifo_rd_en), 1);
    repeat (3) cyc();
    check("sclr_pre_valid", 32'(bus.m_valid), 1);
    do_sclr();
    check("sclr_valid", 32'(bus.m_valid), 0);
    check("sclr_cnt", 32'(beat_cnt), 0);
    bus.m_ready = 1'b1;
    send(8'h3C);
    wait_valid("sclr_next_valid");
    check("sclr_next_data", 32'(bus.m_data), 32'h3C);
    cyc();
    check("sclr_next_cnt", 32'(beat_cnt), 1);

    // Random ready against the ordered scoreboard.
    do_sclr();
    for (int i = 0; i < 200; i++) send(8'($urandom_range(0, 255)));
    wait_drain("rand_drain", 4000, 1'b1);
    check("rand_cnt", 32'(beat_cnt), 200);
    check("rand_cnt_model", 32'(beat_cnt), 32'(model_cnt));
    check("rand_cnt4", 32'(beat_cnt4), 32'(model_cnt % 16));

    // Counter wrap on the 4-bit twin.
    do_sclr();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(8'(8'hC0 + i));
    wait_drain("wrap_drain", 100, 1'b0);
    check("wrap_cnt16", 32'(beat_cnt), 17);
    check("wrap_cnt4", 32'(beat_cnt4), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fifo_rd_stream
`default_nettype wire

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter placed directly downstream of the team's synchronous FIFO. It converts the FIFO's `rd_en`/registered-`dout` interface, where data arrives one cycle after the read, into a valid/ready stream master. A small prefetch buffer sustains one beat per clock with no combinational path from `m_ready` to `fifo_rd_en`. It also keeps a wrapping count of delivered beats for debug.

## Interface
Parameters:
- `DATA_WIDTH`, 8, payload width; must equal the FIFO's data width.
- `BUF_DEPTH`, 3, prefetch buffer entries; legal range ≥ 3.
- `CNT_WIDTH`, 16, width of `beat_cnt`.

Ports:
- `clk`  in  1  clock.
- `aclr_n`  in  1  reset, asynchronous, active-low.
- `sclr_n`  in  1  synchronous clear, active-low; shared with the FIFO.
- `fifo_empty`  in  1  FIFO registered empty flag.
- `fifo_dout`  in  DATA_WIDTH  FIFO registered read data.
- `fifo_rd_en`  out  1  read request to the FIFO.
- `m_valid`  out  1  stream beat valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DATA_WIDTH  stream payload.
- `beat_cnt`  out  CNT_WIDTH  accepted beats, wraps modulo 2^CNT_WIDTH.

## Operation
- **State:**
  - circular buffer `buf[0:BUF_DEPTH-1]` with `head`/`tail` pointers;
  - occupancy `occ` (0..BUF_DEPTH);
  - flag `pend`, meaning a FIFO read was issued last cycle and its data is on `fifo_dout` this cycle.
- **Issue rule:** `fifo_rd_en = sclr_n && !fifo_empty && (occ + pend < BUF_DEPTH)`.
  - Depends only on registered state plus `fifo_empty`; never on `m_ready`.
- **Next pend:** `pend_next = fifo_rd_en`.
- **Capture:** when `pend` = 1, write `fifo_dout` into `buf[tail]` and advance `tail`.
  - `fifo_dout` is never sampled when `pend` = 0, because the FIFO holds its stale `dout`.
- **Pop:** when `m_valid && m_ready`, advance `head` and increment `beat_cnt`.
- **Occupancy:** `occ_next = occ + pend - pop`.
  - Capture and pop in the same cycle leave `occ` unchanged.
  - Pointers wrap at `BUF_DEPTH-1` to 0, using explicit compare; `BUF_DEPTH` need not be a power of two.
- **Outputs:** `m_valid = (occ != 0)`; `m_data = buf[head]`.
  - Once `m_valid` is asserted, `m_data` and `m_valid` hold until accepted (AXI-style stability).
- **Overflow:** the issue rule guarantees a capture always has space. Capture with `occ == BUF_DEPTH` is a design error and is covered by an assertion.
- **sclr_n low:**
  - `occ`, `pend`, pointers and `beat_cnt` clear to 0, and `fifo_rd_en` is forced to 0.
  - An in-flight read is discarded; the FIFO clears on the same edge.

## Timing
- **Reset values (aclr_n low):** `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `beat_cnt`=0. Internally `occ`=0, `pend`=0, `head`=`tail`=0.
- **Latency:**
  - `fifo_empty` falls in cycle N → `fifo_rd_en`=1 in N.
  - `fifo_dout` is valid in N+1 and captured at the end of N+1.
  - `m_valid`=1 in N+2.
- **Throughput:** one beat per clock at steady state with `m_ready` held high (`occ`=1, `pend`=1 each cycle).
- **Backpressure:** with `m_ready`=0, at most `BUF_DEPTH` words leave the FIFO. `fifo_rd_en` then stays 0 until a pop.
- **Simultaneous capture + pop** with `occ`=0 is impossible, since `m_valid`=0. No bypass path exists.
- **aclr_n mid-transfer:** all state clears immediately. Any data on `fifo_dout` is ignored after release because `pend`=0.

## Structure
- No shared-package content is required. If a common FIFO package exists, it holds only a `clog2`-style width helper.
- Sub-module `stream_prefetch_buf`: parameterised circular buffer (write, pop, `occ`, head data). The top level keeps the issue logic, `pend` and `beat_cnt`.
- Assertions:
  - no capture when full;
  - `fifo_rd_en` implies `!fifo_empty`;
  - `m_data` stable while `m_valid && !m_ready`.

## Test plan
Bench uses the team's sync FIFO as the real upstream model, `DATA_WIDTH`=8, `BUF_DEPTH`=3.
- **Single word:** write 0xA5 into the empty FIFO, `m_ready`=1 → `fifo_rd_en` pulses once; `m_valid`=1 with `m_data`=0xA5 two cycles after `fifo_empty` falls; `beat_cnt`=1.
- **Burst:** FIFO preloaded with 0x01..0x08, `m_ready`=1 → eight consecutive beats 0x01..0x08 with no bubbles after the first; `beat_cnt`=8.
- **Backpressure:** preload 0x10..0x17, `m_ready`=0 → exactly 3 reads issued; `m_valid`=1 holding 0x10; FIFO `usedw`=5. Raise `m_ready` → 0x10..0x17 delivered in order.
- **Random ready:** 200 random words with 50% random `m_ready` → output order equals input order and no word is lost or duplicated.
- **sclr mid-burst:** assert `sclr_n`=0 for one cycle while `pend`=1 and `occ`=2 → next cycle `m_valid`=0, `beat_cnt`=0; a subsequent write of 0x3C is the next beat.
- **Count wrap:** with `CNT_WIDTH`=4, deliver 17 beats → `beat_cnt`=1.
